// File: rtl/rename_unit.sv
// Register rename stage: RAT lookup, free-list allocation, retire return.
// Optional stall counter enabled by defining RENAME_STALL_CNT_EN.
module rename_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int TAG_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_prs1,
  output logic [TAG_W-1:0] out_prs2,
  output logic [TAG_W-1:0] out_prd,
  output logic [TAG_W-1:0] out_old_prd,
  output logic             out_rd_wr,
  input  logic             retire_valid,
  input  logic [TAG_W-1:0] retire_old_prd,
  output logic [5:0]       free_count,
`ifdef RENAME_STALL_CNT_EN
  output logic [31:0]      stall_cycles,
`endif
  output logic             err_overflow
);

  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam logic [5:0] FL_FULL = 6'(FL_DEPTH);

  logic [TAG_W-1:0] rat [ARCH_REGS];
  logic [TAG_W-1:0] fl  [FL_DEPTH];
  logic [4:0]       head;
  logic [4:0]       tail;
  logic [5:0]       count;

  logic             alloc_needed;
  logic             out_free;
  logic             accept;
  logic             pop;
  logic             push;
  logic             drop;
  logic [TAG_W-1:0] head_tag;
  logic [TAG_W-1:0] rs1_tag;
  logic [TAG_W-1:0] rs2_tag;
  logic [TAG_W-1:0] rd_tag;

  // Handshake, allocation and retire decisions for this cycle.
  always_comb begin
    alloc_needed = in_rd_wr && (in_rd != 5'd0);
    out_free     = !out_valid || out_ready;
    in_ready     = out_free && (!alloc_needed || count != 6'd0);
    accept       = in_valid && in_ready;
    pop          = accept && alloc_needed;
    push         = retire_valid && (retire_old_prd != '0)
                   && (count != FL_FULL);
    drop         = retire_valid && (retire_old_prd != '0)
                   && (count == FL_FULL);
    head_tag     = fl[head];
    rs1_tag      = (in_rs1 == 5'd0) ? '0 : rat[in_rs1];
    rs2_tag      = (in_rs2 == 5'd0) ? '0 : rat[in_rs2];
    rd_tag       = (in_rd == 5'd0) ? '0 : rat[in_rd];
  end

  // Alias table: identity at reset, x0 never remapped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++)
        rat[i] <= TAG_W'(i);
    end else if (pop) begin
      rat[in_rd] <= head_tag;
    end
  end

  // Free-list FIFO: retire pushes at tail, allocation pops at head.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        fl[i] <= TAG_W'(ARCH_REGS + i);
      head  <= '0;
      tail  <= '0;
      count <= FL_FULL;
    end else begin
      if (push) begin
        fl[tail] <= retire_old_prd;
        tail     <= tail + 5'd1;
      end
      if (pop)
        head <= head + 5'd1;
      count <= count + {5'd0, push} - {5'd0, pop};
    end
  end

  // Output register: loads on accept, holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_prs1    <= '0;
      out_prs2    <= '0;
      out_prd     <= '0;
      out_old_prd <= '0;
      out_rd_wr   <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_prs1    <= rs1_tag;
      out_prs2    <= rs2_tag;
      out_prd     <= pop ? head_tag : '0;
      out_old_prd <= pop ? rd_tag : '0;
      out_rd_wr   <= pop;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky flag for a retire that found the free list full.
  always_ff @(posedge clk) begin
    if (rst)
      err_overflow <= 1'b0;
    else if (drop)
      err_overflow <= 1'b1;
  end

  assign free_count = count;

`ifdef RENAME_STALL_CNT_EN
  // Counts cycles blocked only by an empty free list.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (in_valid && alloc_needed && count == 6'd0
             && out_free && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule
